// File: rtl/div_pkg.sv
// Shared constants and types for the iterative RV32M divider.
package div_pkg;

  localparam int XLEN = 32;

  localparam logic [2:0] F3_DIV  = 3'b100;
  localparam logic [2:0] F3_DIVU = 3'b101;
  localparam logic [2:0] F3_REM  = 3'b110;
  localparam logic [2:0] F3_REMU = 3'b111;

  localparam logic [XLEN-1:0] OVF_DIVIDEND = 32'h8000_0000;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_e;

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift in the next dividend bit, subtract the
// divisor when it fits, and report the resulting quotient bit.
module div_step #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rem_i,
  input  logic [XLEN-1:0] divisor_i,
  input  logic            dividend_bit_i,
  output logic [XLEN-1:0] rem_o,
  output logic            quot_bit_o
);

  logic [XLEN:0]   shifted;
  logic [XLEN-1:0] diff;

  // The remainder stays below the divisor, so the true difference always fits XLEN bits.
  always_comb begin
    shifted    = {rem_i, dividend_bit_i};
    diff       = shifted[XLEN-1:0] - divisor_i;
    quot_bit_o = (shifted >= {1'b0, divisor_i});
    rem_o      = quot_bit_o ? diff : shifted[XLEN-1:0];
  end

endmodule

// File: rtl/div_sequencer.sv
// Multi-cycle RV32M divider: one restoring step per cycle on operand magnitudes,
// with divide-by-zero and signed overflow answered without iterating.
module div_sequencer
  import div_pkg::*;
#(
  parameter int XLEN  = div_pkg::XLEN,
  parameter int STEPS = div_pkg::XLEN
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic [4:0]      rd_in,
  input  logic            flush,
  output logic            busy,
  output logic            stall,
  output logic            valid_out,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rd_out
);

  localparam logic [5:0] LastStep = 6'(STEPS - 1);

  state_e          state_q;
  logic [5:0]      cnt_q;
  logic [XLEN-1:0] dividend_q, divisor_q, rem_q, quot_q, result_q;
  logic [4:0]      rd_q, rdOut_q;
  logic            remSel_q, negQuot_q, negRem_q, valid_q;

  logic            isSigned, accept, divZero, overflow;
  logic [XLEN-1:0] absA_d, absB_d, special_d, quotRaw_d, final_d;
  logic [XLEN-1:0] stepRem;
  logic            stepBit;

  div_step #(.XLEN(XLEN)) u_step (
    .rem_i          (rem_q),
    .divisor_i      (divisor_q),
    .dividend_bit_i (dividend_q[XLEN-1]),
    .rem_o          (stepRem),
    .quot_bit_o     (stepBit)
  );

  always_comb begin
    isSigned  = ~funct3[0];
    accept    = (state_q == IDLE) && start && funct3[2] && !flush && !rst;
    divZero   = (rs2 == '0);
    overflow  = isSigned && (rs1 == OVF_DIVIDEND) && (rs2 == '1);
    absA_d    = (isSigned && rs1[XLEN-1]) ? -rs1 : rs1;
    absB_d    = (isSigned && rs2[XLEN-1]) ? -rs2 : rs2;
    if (funct3[1]) special_d = divZero ? rs1 : '0;
    else           special_d = divZero ? '1  : OVF_DIVIDEND;
    // Final quotient/remainder include the step completing on this edge.
    quotRaw_d = {quot_q[XLEN-2:0], stepBit};
    if (remSel_q) final_d = negRem_q  ? -stepRem   : stepRem;
    else          final_d = negQuot_q ? -quotRaw_d : quotRaw_d;
  end

  assign busy      = (state_q != IDLE);
  assign stall     = accept || (state_q == CALC);
  assign valid_out = valid_q;
  assign result    = result_q;
  assign rd_out    = rdOut_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      dividend_q <= '0;
      divisor_q  <= '0;
      rem_q      <= '0;
      quot_q     <= '0;
      result_q   <= '0;
      rd_q       <= '0;
      rdOut_q    <= '0;
      remSel_q   <= 1'b0;
      negQuot_q  <= 1'b0;
      negRem_q   <= 1'b0;
      valid_q    <= 1'b0;
    end else if (flush) begin
      state_q <= IDLE;
      valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          valid_q <= 1'b0;
          if (accept) begin
            remSel_q   <= funct3[1];
            negQuot_q  <= isSigned && (rs1[XLEN-1] ^ rs2[XLEN-1]);
            negRem_q   <= isSigned && rs1[XLEN-1];
            rd_q       <= rd_in;
            dividend_q <= absA_d;
            divisor_q  <= absB_d;
            rem_q      <= '0;
            quot_q     <= '0;
            cnt_q      <= '0;
            if (divZero || overflow) begin
              state_q  <= DONE;
              result_q <= special_d;
              rdOut_q  <= rd_in;
              valid_q  <= 1'b1;
            end else begin
              state_q <= CALC;
            end
          end
        end
        CALC: begin
          rem_q      <= stepRem;
          quot_q     <= quotRaw_d;
          dividend_q <= {dividend_q[XLEN-2:0], 1'b0};
          if (cnt_q == LastStep) begin
            cnt_q    <= '0;
            state_q  <= DONE;
            result_q <= final_d;
            rdOut_q  <= rd_q;
            valid_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 6'd1;
          end
        end
        DONE: begin
          valid_q <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          valid_q <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_sequencer.sv
// Directed bench for div_sequencer: an arithmetic reference model checked every
// cycle, plus literal expectations for the listed corner cases.
module tb_div_sequencer;

  logic        clk = 1'b0;
  logic        rst, start, flush;
  logic [2:0]  funct3;
  logic [31:0] rs1, rs2;
  logic [4:0]  rd_in;
  logic        busy, stall, valid_out;
  logic [31:0] result;
  logic [4:0]  rd_out;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  bit checkEn = 1'b0;

  int          mLeft   = 0;
  logic [31:0] mResult = '0, mPend = '0;
  logic [4:0]  mRd     = '0, mPendRd = '0;
  bit          mSpecial;

  div_sequencer #(.XLEN(32), .STEPS(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .funct3    (funct3),
    .rs1       (rs1),
    .rs2       (rs2),
    .rd_in     (rd_in),
    .flush     (flush),
    .busy      (busy),
    .stall     (stall),
    .valid_out (valid_out),
    .result    (result),
    .rd_out    (rd_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] refCalc(input logic [2:0] f, input logic [31:0] a,
                                          input logic [31:0] b, output bit special);
    logic [31:0] q, r;
    special = 1'b0;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF; r = a; special = 1'b1;
    end else if (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000; r = 32'd0; special = 1'b1;
    end else if (!f[0]) begin
      q = $signed(a) / $signed(b);
      r = $signed(a) % $signed(b);
    end else begin
      q = a / b;
      r = a % b;
    end
    return f[1] ? r : q;
  endfunction

  // mLeft counts cycles until the unit is idle again; the final one carries the pulse.
  always @(posedge clk) begin
    if (rst) begin
      mLeft = 0; mResult = '0; mRd = '0;
    end else if (flush) begin
      mLeft = 0;
    end else if (mLeft == 0) begin
      if (start && funct3[2]) begin
        mPend   = refCalc(funct3, rs1, rs2, mSpecial);
        mPendRd = rd_in;
        mLeft   = mSpecial ? 1 : 33;
        if (mLeft == 1) begin mResult = mPend; mRd = mPendRd; end
      end
    end else begin
      mLeft = mLeft - 1;
      if (mLeft == 1) begin mResult = mPend; mRd = mPendRd; end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("[TB] FAIL %s: actual=%h required=%h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic applyStimulus(input logic st, input logic [2:0] f, input logic [31:0] a,
                               input logic [31:0] b, input logic [4:0] rd);
    start = st; funct3 = f; rs1 = a; rs2 = b; rd_in = rd;
  endtask

  always @(negedge clk) begin
    if (checkEn) begin
      checkOutput("busy",      32'(busy),      32'(mLeft != 0));
      checkOutput("stall",     32'(stall),     32'((mLeft >= 2) ||
                  (mLeft == 0 && start && funct3[2] && !flush && !rst)));
      checkOutput("valid_out", 32'(valid_out), 32'(mLeft == 1));
      checkOutput("result",    result,         mResult);
      checkOutput("rd_out",    32'(rd_out),    32'(mRd));
    end
  end

  // Latency is the edge count from the accept edge to the edge that samples the pulse.
  task automatic runOp(input string name, input logic [2:0] f, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] rd,
                       input logic [31:0] expRes, input int expLat);
    int t0, lat;
    applyStimulus(1'b1, f, a, b, rd);
    @(posedge clk); #1;
    t0 = cyc;
    start = 1'b0;
    lat = -1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (valid_out) begin
        lat = cyc + 1 - t0;
        break;
      end
    end
    checkOutput({name, " latency"}, 32'(lat), 32'(expLat));
    checkOutput({name, " result"}, result, expRes);
    checkOutput({name, " rd_out"}, 32'(rd_out), 32'(rd));
    checkOutput({name, " stall"}, 32'(stall), 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    int          t0, t1, nValid, lat;
    logic [2:0]  f;
    logic [31:0] a, b, e;
    bit          sp;

    rst = 1'b1; flush = 1'b0;
    applyStimulus(1'b0, 3'b000, 32'd0, 32'd0, 5'd0);
    repeat (2) @(posedge clk);
    #1;
    checkEn = 1'b1;
    checkOutput("reset busy",   32'(busy),      32'd0);
    checkOutput("reset stall",  32'(stall),     32'd0);
    checkOutput("reset valid",  32'(valid_out), 32'd0);
    checkOutput("reset result", result,         32'd0);
    checkOutput("reset rd_out", 32'(rd_out),    32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    runOp("div 100/7",       3'b100, 32'd100,        32'd7,          5'd5,  32'd14,         33);
    runOp("rem -7/2",        3'b110, 32'hFFFF_FFF9,  32'd2,          5'd6,  32'hFFFF_FFFF,  33);
    runOp("div -7/2",        3'b100, 32'hFFFF_FFF9,  32'd2,          5'd7,  32'hFFFF_FFFD,  33);
    runOp("divu max/1",      3'b101, 32'hFFFF_FFFF,  32'd1,          5'd8,  32'hFFFF_FFFF,  33);
    runOp("remu max/16",     3'b111, 32'hFFFF_FFFF,  32'h10,         5'd9,  32'h0000_000F,  33);
    runOp("div 5/0",         3'b100, 32'd5,          32'd0,          5'd10, 32'hFFFF_FFFF,  1);
    runOp("rem 5/0",         3'b110, 32'd5,          32'd0,          5'd11, 32'd5,          1);
    runOp("div ovf",         3'b100, 32'h8000_0000,  32'hFFFF_FFFF,  5'd12, 32'h8000_0000,  1);
    runOp("rem ovf",         3'b110, 32'h8000_0000,  32'hFFFF_FFFF,  5'd13, 32'd0,          1);
    runOp("divu min/max",    3'b101, 32'h8000_0000,  32'hFFFF_FFFF,  5'd14, 32'd0,          33);
    runOp("rem 7/-2",        3'b110, 32'd7,          32'hFFFF_FFFE,  5'd15, 32'd1,          33);
    runOp("div 7/-2",        3'b100, 32'd7,          32'hFFFF_FFFE,  5'd16, 32'hFFFF_FFFD,  33);
    runOp("remu 5/0",        3'b111, 32'd5,          32'd0,          5'd17, 32'd5,          1);

    for (int i = 0; i < 6; i++) begin
      f = {1'b1, 2'($urandom_range(0, 3))};
      a = $urandom;
      b = (i % 3 == 0) ? 32'($urandom_range(1, 20)) : $urandom;
      e = refCalc(f, a, b, sp);
      runOp("random", f, a, b, 5'(20 + i), e, sp ? 1 : 33);
    end

    // start held high into DONE must not launch a second operation
    applyStimulus(1'b1, 3'b100, 32'd9, 32'd0, 5'd3);
    @(posedge clk); #1;
    @(posedge clk); #1;
    start = 1'b0;
    checkOutput("start in DONE busy", 32'(busy), 32'd0);
    @(posedge clk); #1;

    applyStimulus(1'b1, 3'b100, 32'd20, 32'd3, 5'd2);
    flush = 1'b1;
    #1;
    checkOutput("flush+start stall", 32'(stall), 32'd0);
    @(posedge clk); #1;
    flush = 1'b0; start = 1'b0;
    checkOutput("flush+start busy", 32'(busy), 32'd0);
    @(posedge clk); #1;

    applyStimulus(1'b1, 3'b100, 32'd1000, 32'd3, 5'd7);
    @(posedge clk); #1;
    t0 = cyc;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    checkOutput("flush busy", 32'(busy), 32'd0);
    applyStimulus(1'b1, 3'b101, 32'd50, 32'd5, 5'd9);
    @(posedge clk); #1;
    t1 = cyc;
    start = 1'b0;
    nValid = 0;
    while (cyc < t0 + 40) begin
      @(negedge clk);
      if (valid_out) nValid++;
    end
    checkOutput("flush no valid", 32'(nValid), 32'd0);
    lat = -1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (valid_out) begin
        lat = cyc + 1 - t1;
        break;
      end
    end
    checkOutput("after flush latency", 32'(lat), 32'd33);
    checkOutput("after flush result", result, 32'd10);
    checkOutput("after flush rd_out", 32'(rd_out), 32'd9);
    @(posedge clk); #1;

    applyStimulus(1'b1, 3'b110, 32'd77, 32'd4, 5'd12);
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    checkOutput("mid rst busy",   32'(busy),      32'd0);
    checkOutput("mid rst stall",  32'(stall),     32'd0);
    checkOutput("mid rst valid",  32'(valid_out), 32'd0);
    checkOutput("mid rst result", result,         32'd0);
    checkOutput("mid rst rd_out", 32'(rd_out),    32'd0);
    rst = 1'b0;
    applyStimulus(1'b1, 3'b000, 32'd10, 32'd2, 5'd1);
    #1;
    checkOutput("non-div stall", 32'(stall), 32'd0);
    @(posedge clk); #1;
    start = 1'b0;
    checkOutput("non-div busy", 32'(busy), 32'd0);
    @(posedge clk); #1;

    runOp("div after rst", 3'b100, 32'd100, 32'd7, 5'd4, 32'd14, 33);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #300000;
    bad++;
    $display("[TB] FAIL watchdog: actual=running required=finished");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
